trdb_branch_map_ctrl: RTL

//  Sequences trdb_branch_map: decides when the accumulated map is drained into a packet and flushes it.

---
 rtl/trdb_pkg.sv | 18 +
 rtl/trdb_branch_map_ctrl.sv | 104 ++++++++++
 2 files changed

// File: rtl/trdb_pkg.sv
// Shared types and widths for the trace debugger branch-map path.
package trdb_pkg;

  localparam int unsigned BRANCH_MAP_LEN   = 31;
  localparam int unsigned BRANCH_COUNT_LEN = 5;

  typedef enum logic [1:0] {
    REASON_NONE    = 2'd0,
    REASON_FULL    = 2'd1,
    REASON_TRIGGER = 2'd2
  } drain_reason_e;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/trdb_branch_map_ctrl.sv
// Decides when the accumulated branch map is drained, snapshots it and offers it
// to the packet emitter on a valid/ready port; stalls the core when a full map cannot drain.
module trdb_branch_map_ctrl
  import trdb_pkg::*;
#(
  parameter int unsigned MAP_LEN  = BRANCH_MAP_LEN,
  parameter int unsigned CNT_LEN  = BRANCH_COUNT_LEN,
  parameter int unsigned FULL_THR = 31
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [MAP_LEN-1:0] map_i,
  input  logic [CNT_LEN-1:0] branches_i,
  input  logic               trigger_i,
  input  logic               pkt_ready_i,
  output logic               pkt_valid_o,
  output logic [MAP_LEN-1:0] pkt_map_o,
  output logic [CNT_LEN-1:0] pkt_branches_o,
  output logic [1:0]         pkt_reason_o,
  output logic               flush_o,
  output logic               stall_o,
  output logic               trig_drop_o
);

  localparam logic [CNT_LEN-1:0] FullThr = CNT_LEN'(FULL_THR);

  ctrl_state_e        state_q, state_d;
  logic [MAP_LEN-1:0] snap_map_q;
  logic [CNT_LEN-1:0] snap_cnt_q;
  drain_reason_e      reason_q;
  logic               pend_trig_q;
  logic               drop_q;

  logic free;
  logic cap_trig;
  logic cap_full;
  logic capture;

  assign pkt_valid_o = (state_q == PEND);
  // The buffer is reusable this cycle if it is empty or being handed off right now.
  assign free     = ~pkt_valid_o | pkt_ready_i;
  assign cap_trig = trigger_i | pend_trig_q;
  assign cap_full = (branches_i >= FullThr);
  assign capture  = free & (cap_trig | cap_full) & ~rst_i;

  assign flush_o        = capture;
  assign stall_o        = cap_full & ~free;
  assign pkt_map_o      = snap_map_q;
  assign pkt_branches_o = snap_cnt_q;
  assign pkt_reason_o   = reason_q;
  assign trig_drop_o    = drop_q;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (capture) state_d = PEND;
      PEND: if (pkt_ready_i && !capture) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: the snapshot is a handful of flops, not a memory, so it is reset to keep
  // the outputs defined right after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      snap_map_q <= '0;
      snap_cnt_q <= '0;
      reason_q   <= REASON_NONE;
    end else if (capture) begin
      snap_map_q <= map_i;
      snap_cnt_q <= branches_i;
      reason_q   <= cap_trig ? REASON_TRIGGER : REASON_FULL;
    end
  end

  // A trigger that cannot be captured waits in one pending slot; a second one is lost.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_trig_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      if (capture) begin
        pend_trig_q <= 1'b0;
      end else if (trigger_i && !free) begin
        pend_trig_q <= 1'b1;
      end
      if (trigger_i && !free && pend_trig_q) begin
        drop_q <= 1'b1;
      end
    end
  end

endmodule
